// File: rtl/moore_sw_pkg.sv
// Shared definitions for the two-state Moore switch receiver and its
// transmit-side sequence encoder: state encodings, encoder FSM states and
// the sw_in code constants.
package moore_sw_pkg;

  // Receiver state encodings (s1 is the receiver reset state)
  localparam logic S1 = 1'b0;
  localparam logic S2 = 1'b1;

  // Encoder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } enc_state_t;

  // sw_in code constants
  localparam logic [1:0] SW_ZERO  = 2'b00;
  localparam logic [1:0] SW_ONE   = 2'b01;
  localparam logic [1:0] SW_TWO   = 2'b10;
  localparam logic [1:0] SW_THREE = 2'b11;

endpackage

// File: rtl/sw_seq_encoder_if.sv
// Symbol handshake between the sequence source (master) and the encoder
// (slave): one desired receiver state per accepted valid/ready transfer.
interface sw_seq_encoder_if;

  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (
    output in_valid,
    output in_bit,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    output in_ready
  );

endinterface

// File: rtl/sw_code_sel.sv
// Combinational sw_in code table: given the modelled receiver state, the
// wanted next state and the alternate-code phase, pick the code that forces
// that transition. Model 0 / want 0 has a single legal code.
module sw_code_sel
  import moore_sw_pkg::*;
(
  input  logic       model_i,
  input  logic       want_i,
  input  logic       alt_i,
  output logic [1:0] sw_o
);

  // Primary code when alt_i is low, alternate code when high
  always_comb begin
    sw_o = SW_ZERO;
    unique case ({model_i, want_i})
      2'b00:   sw_o = SW_ZERO;
      2'b01:   sw_o = alt_i ? SW_THREE : SW_ONE;
      2'b11:   sw_o = alt_i ? SW_TWO   : SW_ZERO;
      2'b10:   sw_o = alt_i ? SW_THREE : SW_ONE;
      default: sw_o = SW_ZERO;
    endcase
  end

endmodule

// File: rtl/sw_seq_encoder.sv
// Transmit-side driver for the two-state Moore switch receiver. Accepts one
// desired receiver state per handshake, presents the forcing sw code for a
// setup window, pulses ctrl for one cycle, then holds the code for a hold
// window. The receiver state is tracked in model_state.
module sw_seq_encoder
  import moore_sw_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter bit          ALT_ROTATE = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  sw_seq_encoder_if.slave    sym_if,
  output logic [1:0]         sw_out,
  output logic               ctrl_out,
  output logic               model_state,
  output logic               busy,
  output logic [CNT_W-1:0]   sym_count
);

  // Phase counter reload values; the counter counts down to zero inside
  // SETUP and HOLD, so a window of N cycles loads N-1.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HOLD_LD  = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

  enc_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       sw_q, sw_d;
  logic             ctrl_q, ctrl_d;
  logic             want_q, want_d;
  logic             model_q, model_d;
  logic             alt_q, alt_d;
  logic [CNT_W-1:0] sym_q, sym_d;
  logic             hs;
  logic [1:0]       code;

  assign hs = sym_if.in_valid && (state_q == IDLE);

  // Code is chosen from the live in_bit so it can be registered at the
  // handshake edge and appear on sw_out one cycle later.
  sw_code_sel u_code_sel (
    .model_i (model_q),
    .want_i  (sym_if.in_bit),
    .alt_i   (alt_q),
    .sw_o    (code)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SETUP -> STROBE -> (HOLD) -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = SETUP;
      SETUP:   if (cnt_q == 4'd0) state_d = STROBE;
      STROBE:  state_d = (HOLD_CYC == 0) ? IDLE : HOLD;
      HOLD:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; ctrl is registered so it is high exactly
  // while the FSM sits in STROBE.
  always_comb begin
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    want_d  = want_q;
    model_d = model_q;
    alt_d   = alt_q;
    sym_d   = sym_q;
    ctrl_d  = (state_d == STROBE);
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          sw_d   = code;
          want_d = sym_if.in_bit;
          cnt_d  = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      STROBE: begin
        model_d = want_q;
        sym_d   = sym_q + CNT_W'(1);
        if (ALT_ROTATE) alt_d = ~alt_q;
        cnt_d   = HOLD_LD;
      end
      HOLD: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Output and datapath registers; reset realigns with the receiver reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      sw_q    <= SW_ZERO;
      ctrl_q  <= 1'b0;
      want_q  <= S1;
      model_q <= S1;
      alt_q   <= 1'b0;
      sym_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      ctrl_q  <= ctrl_d;
      want_q  <= want_d;
      model_q <= model_d;
      alt_q   <= alt_d;
      sym_q   <= sym_d;
    end
  end

  assign sym_if.in_ready = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign sw_out          = sw_q;
  assign ctrl_out        = ctrl_q;
  assign model_state     = model_q;
  assign sym_count       = sym_q;

endmodule

// File: tb/tb_sw_seq_encoder.sv
// Bench for sw_seq_encoder: three instances (default timing, long
// setup/hold, and alternate codes with a 2-bit counter and no hold window)
// driven with directed symbol sequences; the third also feeds a receiver
// model whose state is compared with the encoder's model.
module tb_sw_seq_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] rst;
  logic [2:0] vld;
  logic [2:0] bin;
  logic [2:0] rdy_w;
  logic [2:0] ctrl_w;
  logic [2:0] model_w;
  logic [2:0] busy_w;
  logic [1:0] sw_w [3];
  logic [7:0] sym_a;
  logic [7:0] sym_b;
  logic [1:0] sym_c;

  int total = 0;
  int bad   = 0;
  int last_hs [3];

  sw_seq_encoder_if if_a ();
  sw_seq_encoder_if if_b ();
  sw_seq_encoder_if if_c ();

  assign if_a.in_valid = vld[0];
  assign if_a.in_bit   = bin[0];
  assign rdy_w[0]      = if_a.in_ready;
  assign if_b.in_valid = vld[1];
  assign if_b.in_bit   = bin[1];
  assign rdy_w[1]      = if_b.in_ready;
  assign if_c.in_valid = vld[2];
  assign if_c.in_bit   = bin[2];
  assign rdy_w[2]      = if_c.in_ready;

  sw_seq_encoder #(.SETUP_CYC(2), .HOLD_CYC(1), .ALT_ROTATE(1'b0), .CNT_W(8)) u_a (
    .clk(clk), .reset(rst[0]), .sym_if(if_a), .sw_out(sw_w[0]), .ctrl_out(ctrl_w[0]),
    .model_state(model_w[0]), .busy(busy_w[0]), .sym_count(sym_a));

  sw_seq_encoder #(.SETUP_CYC(3), .HOLD_CYC(2), .ALT_ROTATE(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .reset(rst[1]), .sym_if(if_b), .sw_out(sw_w[1]), .ctrl_out(ctrl_w[1]),
    .model_state(model_w[1]), .busy(busy_w[1]), .sym_count(sym_b));

  sw_seq_encoder #(.SETUP_CYC(2), .HOLD_CYC(0), .ALT_ROTATE(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .reset(rst[2]), .sym_if(if_c), .sw_out(sw_w[2]), .ctrl_out(ctrl_w[2]),
    .model_state(model_w[2]), .busy(busy_w[2]), .sym_count(sym_c));

  // Receiver FSM model: s1 -> s2 on any nonzero code, s2 -> s1 when sw[0]=1
  logic rx;
  always @(posedge clk) begin
    if (rst[2])        rx <= 1'b0;
    else if (ctrl_w[2]) rx <= (rx == 1'b0) ? (sw_w[2] != 2'b00) : ~sw_w[2][0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ecode(input logic m, input logic w, input logic a);
    if (!m && !w) return 2'b00;
    if (m && w)   return a ? 2'b10 : 2'b00;
    return a ? 2'b11 : 2'b01;
  endfunction

  // One full symbol on instance d; in_bit is flipped right after the
  // handshake to confirm it is ignored while busy.
  task automatic send(input int d, input logic b, input int su, input int ho,
                      input logic [1:0] es, input logic em, input bit per);
    int n;
    n = 0;
    while (!rdy_w[d] && n < 50) begin @(negedge clk); n++; end
    check("ready_wait", rdy_w[d], 1);
    vld[d] = 1'b1;
    bin[d] = b;
    @(negedge clk);
    vld[d] = 1'b0;
    bin[d] = ~b;
    if (per) check("period", cyc - last_hs[d], su + ho + 2);
    last_hs[d] = cyc;
    check("sw_latch", sw_w[d], es);
    check("ready_low", rdy_w[d], 0);
    n = 1;
    while (!ctrl_w[d] && n < 50) begin
      check("sw_setup", sw_w[d], es);
      @(negedge clk);
      n++;
    end
    check("strobe_lat", n, su + 1);
    check("sw_strobe", sw_w[d], es);
    @(negedge clk);
    check("ctrl_1cyc", ctrl_w[d], 0);
    check("model", model_w[d], em);
    n = 0;
    while (!rdy_w[d] && n < 50) begin
      check("sw_hold", sw_w[d], es);
      @(negedge clk);
      n++;
    end
    check("hold_len", n, ho);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       b;
    logic       em, ea;
    logic [1:0] es;
    logic [3:0] seen;
    logic       bits_a [4];
    logic [1:0] sw_a [4];
    logic       bits_pre [7];
    int         n, k;

    bits_a = '{1'b1, 1'b1, 1'b0, 1'b0};
    sw_a   = '{2'b01, 2'b00, 2'b01, 2'b00};
    bits_pre = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    vld = '0;
    bin = '0;
    rst = 3'b111;
    repeat (3) @(negedge clk);
    rst = 3'b000;

    check("rst_sw", sw_w[0], 2'b00);
    check("rst_ctrl", ctrl_w[0], 0);
    check("rst_model", model_w[0], 0);
    check("rst_sym", sym_a, 0);
    check("rst_ready", rdy_w[0], 1);
    check("rst_busy", busy_w[0], 0);

    // Default timing, sequence 1,1,0,0
    for (int i = 0; i < 4; i++) begin
      send(0, bits_a[i], 2, 1, sw_a[i], bits_a[i], i > 0);
      check("sym_a", sym_a, i + 1);
    end

    // Reset during SETUP of the third symbol
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    send(0, 1'b1, 2, 1, 2'b01, 1'b1, 1'b0);
    send(0, 1'b0, 2, 1, 2'b01, 1'b0, 1'b1);
    check("sym_a_pre", sym_a, 2);
    vld[0] = 1'b1;
    bin[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    check("busy_setup", busy_w[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_sw", sw_w[0], 2'b00);
    check("abort_model", model_w[0], 0);
    check("abort_sym", sym_a, 0);
    check("abort_ready", rdy_w[0], 1);
    check("abort_busy", busy_w[0], 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (ctrl_w[0]) n++;
      @(negedge clk);
    end
    check("abort_nostrobe", n, 0);

    // Long setup/hold window
    send(1, 1'b1, 3, 2, 2'b01, 1'b1, 1'b0);
    send(1, 1'b1, 3, 2, 2'b00, 1'b1, 1'b1);
    send(1, 1'b0, 3, 2, 2'b01, 1'b0, 1'b1);
    check("sym_b", sym_b, 3);

    // Alternate codes, 2-bit counter wrap, no hold window, receiver tracking
    check("rst_sym_c", sym_c, 0);
    em = 1'b0;
    ea = 1'b0;
    seen = '0;
    k = 0;
    for (int i = 0; i < 52; i++) begin
      if (i < 5)       b = i[0] ? 1'b0 : 1'b1;
      else if (i < 12) b = bits_pre[i-5];
      else             b = 1'($urandom_range(0, 1));
      es = ecode(em, b, ea);
      send(2, b, 2, 0, es, b, i > 0);
      seen[sw_w[2]] = 1'b1;
      em = b;
      ea = ~ea;
      k++;
      check("sym_c", sym_c, k & 3);
      check("rx_align", rx, model_w[2]);
    end
    check("alt_codes_seen", seen, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
